cacheline_arbiter: RTL

- Shares the single line-wide backing-memory port between the I-cache (fetch-line misses) and the D-cache (load/store-line misses and writebacks).
- Sits between the two caches and the memory / L2 adapter.
- Grant is by fixed D-priority, because a D-side miss freezes the whole pipeline. A starvation counter guarantees forward progress for fetch.
- Every transaction is latched at grant, so the memory port stays stable until the memory responds.

---
 rtl/cacheline_arbiter_if.sv | 35 +++
 rtl/cacheline_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cacheline_arbiter_if.sv
// Bundle of the I-cache, D-cache and backing-memory line ports seen by cacheline_arbiter.
// The slave modport is the arbiter's view; master is the view of the caches and memory around it.
interface cacheline_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] i_addr;
    logic              i_read;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic [ADDR_W-1:0] d_addr;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic [ADDR_W-1:0] m_addr;
    logic              m_read;
    logic              m_write;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;
    logic              m_resp;

    modport slave (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, m_rdata, m_resp,
        output i_rdata, i_resp, d_rdata, d_resp, m_addr, m_read, m_write, m_wdata
    );

    modport master (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata, m_rdata, m_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, m_addr, m_read, m_write, m_wdata
    );
endinterface

// File: rtl/cacheline_arbiter.sv
// Shares one line-wide memory port between I-cache and D-cache: fixed D priority,
// with a starvation counter that forces an I grant after STARVE_MAX consecutive D grants.
module cacheline_arbiter #(
    parameter int LINE_W     = 256,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    cacheline_arbiter_if.slave  bus
);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = {{(ADDR_W-OFF_W){1'b0}}, {OFF_W{1'b1}}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  starve_cnt_r, starve_cnt_s;
    logic [ADDR_W-1:0] m_addr_r, m_addr_s;
    logic              m_read_r, m_read_s;
    logic              m_write_r, m_write_s;
    logic [LINE_W-1:0] m_wdata_r, m_wdata_s;
    logic [LINE_W-1:0] i_rdata_r, i_rdata_s;
    logic [LINE_W-1:0] d_rdata_r, d_rdata_s;
    logic              i_resp_r, i_resp_s;
    logic              d_resp_r, d_resp_s;
    logic              d_req_s;
    logic              starved_s;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & ~OFF_MASK;
    endfunction

    // Grant decision, transaction latching and response capture.
    always_comb begin
        state_s      = state_r;
        starve_cnt_s = starve_cnt_r;
        m_addr_s     = m_addr_r;
        m_read_s     = m_read_r;
        m_write_s    = m_write_r;
        m_wdata_s    = m_wdata_r;
        i_rdata_s    = i_rdata_r;
        d_rdata_s    = d_rdata_r;
        i_resp_s     = 1'b0;
        d_resp_s     = 1'b0;
        d_req_s      = bus.d_read | bus.d_write;
        starved_s    = bus.i_read && (starve_cnt_r == CNT_MAX);

        case (state_r)
            IDLE: begin
                if (d_req_s && !starved_s) begin
                    state_s   = BUSY_D;
                    m_addr_s  = line_align(bus.d_addr);
                    m_write_s = bus.d_write;
                    m_read_s  = bus.d_read & ~bus.d_write;
                    m_wdata_s = bus.d_wdata;
                    if (bus.i_read && (starve_cnt_r != CNT_MAX)) begin
                        starve_cnt_s = starve_cnt_r + CNT_W'(1);
                    end else begin
                        starve_cnt_s = starve_cnt_r;
                    end
                end else if (bus.i_read) begin
                    state_s      = BUSY_I;
                    m_addr_s     = line_align(bus.i_addr);
                    m_read_s     = 1'b1;
                    m_write_s    = 1'b0;
                    starve_cnt_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_I: begin
                if (bus.m_resp) begin
                    state_s   = RESP;
                    m_read_s  = 1'b0;
                    m_write_s = 1'b0;
                    i_rdata_s = bus.m_rdata;
                    i_resp_s  = 1'b1;
                end else begin
                    state_s = BUSY_I;
                end
            end
            BUSY_D: begin
                if (bus.m_resp) begin
                    state_s   = RESP;
                    m_read_s  = 1'b0;
                    m_write_s = 1'b0;
                    d_resp_s  = 1'b1;
                    // A writeback returns no line, so d_rdata keeps its old value.
                    if (m_read_r) begin
                        d_rdata_s = bus.m_rdata;
                    end else begin
                        d_rdata_s = d_rdata_r;
                    end
                end else begin
                    state_s = BUSY_D;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // An I-side that is not waiting cannot be starving.
        if (!bus.i_read) begin
            starve_cnt_s = '0;
        end else begin
            starve_cnt_s = starve_cnt_s;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            starve_cnt_r <= '0;
            m_addr_r     <= '0;
            m_read_r     <= 1'b0;
            m_write_r    <= 1'b0;
            m_wdata_r    <= '0;
            i_rdata_r    <= '0;
            d_rdata_r    <= '0;
            i_resp_r     <= 1'b0;
            d_resp_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            starve_cnt_r <= starve_cnt_s;
            m_addr_r     <= m_addr_s;
            m_read_r     <= m_read_s;
            m_write_r    <= m_write_s;
            m_wdata_r    <= m_wdata_s;
            i_rdata_r    <= i_rdata_s;
            d_rdata_r    <= d_rdata_s;
            i_resp_r     <= i_resp_s;
            d_resp_r     <= d_resp_s;
        end
    end

    assign bus.m_addr  = m_addr_r;
    assign bus.m_read  = m_read_r;
    assign bus.m_write = m_write_r;
    assign bus.m_wdata = m_wdata_r;
    assign bus.i_rdata = i_rdata_r;
    assign bus.i_resp  = i_resp_r;
    assign bus.d_rdata = d_rdata_r;
    assign bus.d_resp  = d_resp_r;
endmodule
